// File: rtl/mac_pkg.sv
// Shared types and helpers for the a*b+c*d+e operand issuer.
package mac_pkg;

    localparam int unsigned OP_W  = 16;
    localparam int unsigned RES_W = 32;

    localparam logic [2:0] FIELD_A = 3'd0;
    localparam logic [2:0] FIELD_B = 3'd1;
    localparam logic [2:0] FIELD_C = 3'd2;
    localparam logic [2:0] FIELD_D = 3'd3;
    localparam logic [2:0] FIELD_E = 3'd4;

    typedef struct packed {
        logic signed [OP_W-1:0] a;
        logic signed [OP_W-1:0] b;
        logic signed [OP_W-1:0] c;
        logic signed [OP_W-1:0] d;
        logic signed [OP_W-1:0] e;
    } tuple_t;

    localparam int unsigned TUPLE_W = $bits(tuple_t);

    // Result the pipeline should produce for a tuple, wrapping at RES_W bits.
    function automatic logic signed [RES_W-1:0] mac_expect(input tuple_t t);
        logic signed [RES_W-1:0] ab;
        logic signed [RES_W-1:0] cd;
        ab = RES_W'(t.a) * RES_W'(t.b);
        cd = RES_W'(t.c) * RES_W'(t.d);
        return ab + cd + RES_W'(t.e);
    endfunction

endpackage

// File: rtl/mac_tuple_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is taken when a pop frees the slot.
module mac_tuple_fifo #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_issuer.sv
// Word-serial operand loader, tuple FIFO and credit-limited issue for the a*b+c*d+e pipeline.
// Optional result checking against locally computed expectations: define MAC_ISSUER_CHECK_EN.
module mac_operand_issuer
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     wr_valid,
    output logic                                     wr_ready,
    input  logic signed [OP_W-1:0]                   wr_data,
    input  logic                                     flush,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic signed [OP_W-1:0]                   m_a,
    output logic signed [OP_W-1:0]                   m_b,
    output logic signed [OP_W-1:0]                   m_c,
    output logic signed [OP_W-1:0]                   m_d,
    output logic signed [OP_W-1:0]                   m_e,
    input  logic                                     r_valid,
    output logic                                     r_ready,
    input  logic signed [RES_W-1:0]                  r_y,
    output logic signed [RES_W-1:0]                  last_y,
    output logic [15:0]                              result_cnt,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic                                     busy,
    output logic                                     err_unexpected,
    output logic                                     err_mismatch
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [2:0]             idx;
    logic signed [OP_W-1:0] stage_a;
    logic signed [OP_W-1:0] stage_b;
    logic signed [OP_W-1:0] stage_c;
    logic signed [OP_W-1:0] stage_d;
    tuple_t                 push_tuple;
    tuple_t                 head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   word_hs;
    logic                   push;
    logic                   issue_hs;
    logic                   res_credit;

    assign issue_hs   = m_valid && m_ready;
    assign wr_ready   = !((idx == FIELD_E) && fifo_full && !issue_hs);
    assign word_hs    = wr_valid && wr_ready && !flush;
    assign push       = word_hs && (idx == FIELD_E);
    assign m_valid    = !fifo_empty && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign res_credit = r_valid && (outstanding != '0);
    assign r_ready    = 1'b1;
    assign busy       = (idx != '0) || !fifo_empty || (outstanding != '0);

    assign m_a = head.a;
    assign m_b = head.b;
    assign m_c = head.c;
    assign m_d = head.d;
    assign m_e = head.e;

    always_comb begin
        push_tuple   = '0;
        push_tuple.a = stage_a;
        push_tuple.b = stage_b;
        push_tuple.c = stage_c;
        push_tuple.d = stage_d;
        push_tuple.e = wr_data;
    end

    mac_tuple_fifo #(
        .WIDTH(TUPLE_W),
        .DEPTH(DEPTH)
    ) u_tuple_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .push (push),
        .pop  (issue_hs),
        .din  (push_tuple),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Staging registers collect a..d; the fifth word goes straight into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            stage_a <= '0;
            stage_b <= '0;
            stage_c <= '0;
            stage_d <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (word_hs) begin
            case (idx)
                FIELD_A: stage_a <= wr_data;
                FIELD_B: stage_b <= wr_data;
                FIELD_C: stage_c <= wr_data;
                FIELD_D: stage_d <= wr_data;
                default: ;
            endcase
            idx <= (idx == FIELD_E) ? '0 : idx + 3'd1;
        end
    end

    // Credits survive flush: results for already-issued tuples still come back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding    <= '0;
            err_unexpected <= 1'b0;
            last_y         <= '0;
            result_cnt     <= '0;
        end else begin
            case ({issue_hs, res_credit})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (r_valid) begin
                last_y     <= r_y;
                result_cnt <= result_cnt + 16'd1;
                if (outstanding == '0) begin
                    err_unexpected <= 1'b1;
                end
            end
        end
    end

`ifdef MAC_ISSUER_CHECK_EN
    logic [RES_W-1:0] exp_din;
    logic [RES_W-1:0] exp_dout;
    logic             exp_empty;
    logic             exp_pop;
    logic             unused_exp_full;

    assign exp_din = mac_expect(head);
    assign exp_pop = r_valid && !exp_empty;

    mac_tuple_fifo #(
        .WIDTH(RES_W),
        .DEPTH(MAX_OUTSTANDING)
    ) u_exp_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(1'b0),
        .push (issue_hs),
        .pop  (exp_pop),
        .din  (exp_din),
        .dout (exp_dout),
        .full (unused_exp_full),
        .empty(exp_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mismatch <= 1'b0;
        end else if (exp_pop && (exp_dout != r_y)) begin
            err_mismatch <= 1'b1;
        end
    end
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mac_operand_issuer.sv
// Scoreboard bench for mac_operand_issuer with a 3-cycle model pipeline.
module tb_mac_operand_issuer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 4;
    localparam int          LAT   = 3;

    typedef logic [4:0][15:0] tup_t;
    typedef struct {
        logic [31:0] val;
        int          cyc;
    } pipe_t;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_a, m_b, m_c, m_d, m_e;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_y;
    logic [31:0] last_y;
    logic [15:0] result_cnt;
    logic [2:0]  outstanding;
    logic        busy;
    logic        err_unexpected;
    logic        err_mismatch;

    mac_operand_issuer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_d(m_d), .m_e(m_e),
        .r_valid(r_valid), .r_ready(r_ready), .r_y(r_y), .last_y(last_y),
        .result_cnt(result_cnt), .outstanding(outstanding), .busy(busy),
        .err_unexpected(err_unexpected), .err_mismatch(err_mismatch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    pipe_t pipe_q[$];
    int    pipe_rd = 0;
    int    ret_budget = -1;
    bit    corrupt_one = 0;
    bit    rand_corrupt = 0;

    // Reference state: loader position, queued tuples, credits, host status.
    int          md_idx;
    logic [15:0] md_stage[4];
    tup_t        md_fq[$];
    logic [31:0] md_exp[$];
    int          md_out;
    logic [31:0] md_last;
    logic [15:0] md_cnt;
    bit          md_eu;
    bit          md_em;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mac(input tup_t t);
        longint s;
        s = longint'($signed(t[0])) * longint'($signed(t[1]))
          + longint'($signed(t[2])) * longint'($signed(t[3]))
          + longint'($signed(t[4]));
        return s[31:0];
    endfunction

    function automatic bit md_mvalid();
        return (md_fq.size() > 0) && (md_out < int'(MAXO));
    endfunction

    function automatic bit md_wready();
        return !(md_idx == 4 && md_fq.size() == int'(DEPTH) && !(md_mvalid() && m_ready));
    endfunction

    task automatic model_reset();
        md_idx = 0;
        md_fq.delete();
        md_exp.delete();
        md_out = 0;
        md_last = '0;
        md_cnt = '0;
        md_eu = 0;
        md_em = 0;
    endtask

    task automatic check_outputs();
        logic [15:0] fld[5];
        string       nm[5];
        tup_t        h;
        fld = '{m_a, m_b, m_c, m_d, m_e};
        nm  = '{"m_a", "m_b", "m_c", "m_d", "m_e"};
        chk("m_valid", 32'(m_valid), 32'(md_mvalid()));
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) chk(nm[i], 32'(fld[i]), 32'd0);
        end else if (md_mvalid()) begin
            h = md_fq[0];
            for (int i = 0; i < 5; i++) chk(nm[i], 32'(fld[i]), 32'(h[i]));
        end
        chk("wr_ready", 32'(wr_ready), 32'(md_wready()));
        chk("r_ready", 32'(r_ready), 32'd1);
        chk("outstanding", 32'(outstanding), 32'(md_out));
        chk("busy", 32'(busy), 32'(md_idx != 0 || md_fq.size() != 0 || md_out != 0));
        chk("last_y", last_y, md_last);
        chk("result_cnt", 32'(result_cnt), 32'(md_cnt));
        chk("err_unexpected", 32'(err_unexpected), 32'(md_eu));
        chk("err_mismatch", 32'(err_mismatch), 32'(md_em));
    endtask

    task automatic model_step();
        bit          iss;
        bit          wrdy;
        int          out_old;
        tup_t        t;
        logic [31:0] e;
        iss     = md_mvalid() && m_ready;
        wrdy    = md_wready();
        out_old = md_out;
        if (iss) begin
            t = md_fq.pop_front();
            pipe_q.push_back('{ref_mac(t), cyc});
            md_exp.push_back(ref_mac(t));
            md_out++;
        end
        if (r_valid) begin
            if (md_exp.size() > 0) begin
                e = md_exp.pop_front();
`ifdef MAC_ISSUER_CHECK_EN
                if (e !== r_y) md_em = 1;
`endif
            end
            if (out_old == 0) md_eu = 1;
            else md_out--;
            md_last = r_y;
            md_cnt  = md_cnt + 16'd1;
        end
        if (wr_valid && wrdy && !flush) begin
            if (md_idx < 4) begin
                md_stage[md_idx] = wr_data;
                md_idx++;
            end else begin
                for (int i = 0; i < 4; i++) t[i] = md_stage[i];
                t[4] = wr_data;
                md_fq.push_back(t);
                md_idx = 0;
            end
        end
        if (flush) begin
            md_idx = 0;
            md_fq.delete();
        end
    endtask

    // Monitor: compare at the falling edge, then advance the model past the next rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check_outputs();
            if (rst_n) model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        r_valid = 1'b0;
        r_y     = 32'($urandom);
        if (rst_n && pipe_rd < pipe_q.size() && pipe_q[pipe_rd].cyc + LAT <= cyc && ret_budget != 0) begin
            r_valid = 1'b1;
            r_y     = pipe_q[pipe_rd].val;
            if (corrupt_one || (rand_corrupt && $urandom_range(0, 15) == 0)) begin
                r_y         = r_y + 32'd1;
                corrupt_one = 0;
            end
            pipe_rd++;
            if (ret_budget > 0) ret_budget--;
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        bit acc;
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_data  = w;
        forever begin
            @(negedge clk);
            acc = wr_ready && !flush;
            tick();
            if (acc) break;
            n++;
            if (n > 50) begin
                chk("wr_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic send_rand_tuple();
        for (int i = 0; i < 5; i++) send_word(16'($urandom));
    endtask

    task automatic drain();
        int n;
        n          = 0;
        m_ready    = 1'b1;
        ret_budget = -1;
        while (md_fq.size() != 0 || md_out != 0) begin
            tick();
            n++;
            if (n > 300) begin
                chk("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
        repeat (2) tick();
    endtask

    task automatic pulse_reset();
        rst_n   = 1'b0;
        pipe_rd = pipe_q.size();
        tick();
        rst_n   = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] w_a[5];
        logic [15:0] w_b[5];
        logic [15:0] stall_w;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
        m_ready = 1'b0; r_valid = 1'b0; r_y = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic tuples, second one returned with a corrupted result.
        m_ready = 1'b1;
        w_a = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
        for (int i = 0; i < 5; i++) send_word(w_a[i]);
        drain();
        corrupt_one = 1;
        w_b = '{-16'sd2, 16'sd3, -16'sd4, -16'sd5, -16'sd1};
        for (int i = 0; i < 5; i++) send_word(w_b[i]);
        drain();
        corrupt_one = 0;

        // Stall: fill the FIFO, hold the last word of tuple 5, then release.
        m_ready = 1'b0;
        for (int t = 0; t < 4; t++) send_rand_tuple();
        for (int i = 0; i < 4; i++) send_word(16'($urandom));
        stall_w  = 16'($urandom);
        wr_valid = 1'b1;
        wr_data  = stall_w;
        repeat (4) tick();
        m_ready = 1'b1;
        send_word(stall_w);
        send_rand_tuple();
        drain();

        // Credit limit with results withheld, then one result released.
        ret_budget = 0;
        m_ready    = 1'b1;
        for (int t = 0; t < 6; t++) send_rand_tuple();
        repeat (4) tick();
        ret_budget = 1;
        repeat (8) tick();
        drain();

        // Wrap case for the expected value.
        for (int i = 0; i < 4; i++) send_word(16'h8000);
        send_word(16'h0000);
        drain();

        // Result with nothing outstanding.
        tick();
        r_valid = 1'b1;
        r_y     = 32'($urandom);
        repeat (3) tick();

        // Reset mid-load, then mid-issue.
        send_word(16'($urandom));
        send_word(16'($urandom));
        pulse_reset();
        ret_budget = 0;
        send_rand_tuple();
        send_rand_tuple();
        tick();
        pulse_reset();
        ret_budget = -1;
        repeat (2) tick();

        // Randomized traffic with flushes, back-pressure and returns.
        rand_corrupt = 1;
        for (int k = 0; k < 800; k++) begin
            tick();
            m_ready    = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            wr_valid   = ($urandom_range(0, 2) != 0);
            wr_data    = 16'($urandom);
            ret_budget = ($urandom_range(0, 3) == 0) ? 0 : -1;
        end
        wr_valid     = 1'b0;
        flush        = 1'b0;
        rand_corrupt = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
